// File: rtl/aes_key_sched_ctrl.sv
// Sequencer and round-key bank for the pipelined AES-128 key expander: accepts a key,
// waits out the expander latency, snapshots the schedule and serves round keys on request.
module aes_key_sched_ctrl #(
    parameter int WIDTH       = 128,
    parameter int NR          = 10,
    parameter int EXP_LATENCY = 10
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                key_load_i,
    input  logic [WIDTH-1:0]    key_i,
    output logic                key_ready_o,
    input  logic                key_clear_i,
    input  logic                cipher_busy_i,
    output logic [WIDTH-1:0]    exp_key_o,
    input  logic [NR*WIDTH-1:0] exp_rk_i,
    output logic                keys_valid_o,
    input  logic                rk_req_i,
    input  logic [3:0]          rk_idx_i,
    output logic                rk_valid_o,
    output logic [WIDTH-1:0]    rk_o,
    output logic                rk_err_o
);

    localparam int CNT_W = (EXP_LATENCY > 0) ? $clog2(EXP_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXP_LATENCY);
    localparam logic [4:0] MAX_IDX = 5'(NR);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        VALID
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             capture;
    logic             rd_ok;
    logic [WIDTH-1:0] bank [0:NR];

    // Ready is also held low while reset is asserted so every output reads 0 in reset.
    assign key_ready_o = rst_n_i && (state != WAIT) && !cipher_busy_i && !key_clear_i;
    assign accept      = key_load_i && key_ready_o;
    assign rd_ok       = keys_valid_o && ({1'b0, rk_idx_i} <= MAX_IDX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        if (key_clear_i) begin
            state_next = IDLE;
        end else if (accept) begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
        end else if (state == WAIT) begin
            if (cnt == '0) begin
                capture    = 1'b1;
                state_next = VALID;
            end else begin
                cnt_next = cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exp_key_o    <= '0;
            keys_valid_o <= 1'b0;
            for (int r = 0; r <= NR; r++) begin
                bank[r] <= '0;
            end
        end else if (key_clear_i) begin
            exp_key_o    <= '0;
            keys_valid_o <= 1'b0;
            for (int r = 0; r <= NR; r++) begin
                bank[r] <= '0;
            end
        end else if (accept) begin
            exp_key_o    <= key_i;
            bank[0]      <= key_i;
            keys_valid_o <= 1'b0;
        end else if (capture) begin
            for (int r = 1; r <= NR; r++) begin
                bank[r] <= exp_rk_i[r*WIDTH-1 -: WIDTH];
            end
            keys_valid_o <= 1'b1;
        end
    end

    // Reads look at the bank as it stood before this edge, so re-key/clear/capture races are benign.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rk_valid_o <= 1'b0;
            rk_err_o   <= 1'b0;
            rk_o       <= '0;
        end else begin
            rk_valid_o <= rk_req_i && rd_ok;
            rk_err_o   <= rk_req_i && !rd_ok;
            if (rk_req_i && rd_ok) begin
                rk_o <= bank[rk_idx_i];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Randomized bench for aes_key_sched_ctrl: a behavioural AES-128 expander feeds the DUT and a
// timestamp-based reference model predicts every output cycle by cycle.
module tb_aes_key_sched_ctrl;

    localparam int WIDTH       = 128;
    localparam int NR          = 10;
    localparam int EXP_LATENCY = 10;

    localparam logic [127:0] AES_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] AES_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] AES_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                key_load = 1'b0;
    logic [WIDTH-1:0]    key = '0;
    logic                key_ready;
    logic                key_clear = 1'b0;
    logic                cipher_busy = 1'b0;
    logic [WIDTH-1:0]    exp_key;
    logic [NR*WIDTH-1:0] exp_rk;
    logic                keys_valid;
    logic                rk_req = 1'b0;
    logic [3:0]          rk_idx = '0;
    logic                rk_valid;
    logic [WIDTH-1:0]    rk;
    logic                rk_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(
        .WIDTH(WIDTH),
        .NR(NR),
        .EXP_LATENCY(EXP_LATENCY)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .key_load_i(key_load),
        .key_i(key),
        .key_ready_o(key_ready),
        .key_clear_i(key_clear),
        .cipher_busy_i(cipher_busy),
        .exp_key_o(exp_key),
        .exp_rk_i(exp_rk),
        .keys_valid_o(keys_valid),
        .rk_req_i(rk_req),
        .rk_idx_i(rk_idx),
        .rk_valid_o(rk_valid),
        .rk_o(rk),
        .rk_err_o(rk_err)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0]  inv;
        logic [7:0]  base;
        logic [15:0] d;
        inv  = 8'h01;
        base = x;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        d = {inv, inv};
        return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [NR*WIDTH-1:0] expand_key(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [NR*WIDTH-1:0] res;
        rc   = 8'h01;
        w[0] = k[127:96];
        w[1] = k[95:64];
        w[2] = k[63:32];
        w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t  = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        res = '0;
        for (int r = 1; r <= NR; r++) begin
            res[r*WIDTH-1 -: WIDTH] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return res;
    endfunction

    // Expander stand-in: a delay line on the key followed by a full expansion.
    logic [WIDTH-1:0] pipe [0:EXP_LATENCY-1];
    always @(posedge clk) begin
        pipe[0] <= exp_key;
        for (int i = 1; i < EXP_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    always_comb exp_rk = expand_key(pipe[EXP_LATENCY-1]);

    // Reference model state, advanced once per clock edge.
    logic             m_valid;
    logic             m_wait;
    logic [WIDTH-1:0] m_bank [0:NR];
    logic [WIDTH-1:0] m_exp_key;
    logic [WIDTH-1:0] m_rk;
    logic             m_rv;
    logic             m_re;
    int               m_cap_at;
    int               cyc;

    task automatic model_reset();
        m_valid   = 1'b0;
        m_wait    = 1'b0;
        m_exp_key = '0;
        m_rk      = '0;
        m_rv      = 1'b0;
        m_re      = 1'b0;
        m_cap_at  = 0;
        for (int r = 0; r <= NR; r++) m_bank[r] = '0;
    endtask

    function automatic logic model_ready();
        return rst_n && !m_wait && !cipher_busy && !key_clear;
    endfunction

    task automatic model_step();
        logic                rdy;
        logic [NR*WIDTH-1:0] sched;
        rdy = !m_wait && !cipher_busy && !key_clear;
        m_rv = 1'b0;
        m_re = 1'b0;
        if (rk_req) begin
            if (m_valid && int'(rk_idx) <= NR) begin
                m_rk = m_bank[rk_idx];
                m_rv = 1'b1;
            end else begin
                m_re = 1'b1;
            end
        end
        if (key_clear) begin
            m_exp_key = '0;
            m_valid   = 1'b0;
            m_wait    = 1'b0;
            for (int r = 0; r <= NR; r++) m_bank[r] = '0;
        end else if (key_load && rdy) begin
            m_exp_key = key;
            m_bank[0] = key;
            m_valid   = 1'b0;
            m_wait    = 1'b1;
            m_cap_at  = cyc + EXP_LATENCY + 1;
        end else if (m_wait && cyc == m_cap_at) begin
            sched = expand_key(m_exp_key);
            for (int r = 1; r <= NR; r++) m_bank[r] = sched[r*WIDTH-1 -: WIDTH];
            m_valid = 1'b1;
            m_wait  = 1'b0;
        end
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check ready, step the model, check at the next falling edge.
    task automatic applyStimulus(input logic ld, input logic [127:0] k, input logic clr,
                                 input logic bsy, input logic rq, input logic [3:0] ix);
        key_load    = ld;
        key         = k;
        key_clear   = clr;
        cipher_busy = bsy;
        rk_req      = rq;
        rk_idx      = ix;
        #1;
        checkOutput("key_ready", 128'(key_ready), 128'(model_ready()));
        @(posedge clk);
        model_step();
        @(negedge clk);
        checkOutput("exp_key", exp_key, m_exp_key);
        checkOutput("keys_valid", 128'(keys_valid), 128'(m_valid));
        checkOutput("rk_valid", 128'(rk_valid), 128'(m_rv));
        checkOutput("rk_err", 128'(rk_err), 128'(m_re));
        checkOutput("rk", rk, m_rk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_ready"}, 128'(key_ready), 128'd0);
        checkOutput({tag, "_exp_key"}, exp_key, 128'd0);
        checkOutput({tag, "_valid"}, 128'(keys_valid), 128'd0);
        checkOutput({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
        checkOutput({tag, "_rk_err"}, 128'(rk_err), 128'd0);
        checkOutput({tag, "_rk"}, rk, 128'd0);
    endtask

    task automatic async_reset(input string tag);
        key_load    = 1'b0;
        key_clear   = 1'b0;
        cipher_busy = 1'b0;
        rk_req      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] k2;
        logic [127:0] k3;
        logic [127:0] rk_key;
        cyc = 0;
        model_reset();
        #3;
        check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] read before any key");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd5);

        $display("[TB] known-answer key load");
        applyStimulus(1'b1, AES_KEY, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(10);
        checkOutput("tv_not_yet_valid", 128'(keys_valid), 128'd0);
        idle(1);
        checkOutput("tv_valid", 128'(keys_valid), 128'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd1);
        checkOutput("tv_rk1", rk, AES_RK1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd10);
        checkOutput("tv_rk10", rk, AES_RK10);

        $display("[TB] out-of-range reads");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd11);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd15);
        checkOutput("bad_rk_hold", rk, AES_RK10);

        $display("[TB] busy lockout and re-key");
        k2 = {$urandom, $urandom, $urandom, $urandom};
        k3 = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(1'b1, k2, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("busy_exp_key", exp_key, AES_KEY);
        applyStimulus(1'b1, k2, 1'b0, 1'b0, 1'b1, 4'd0);
        checkOutput("rekey_old_rk0", rk, AES_KEY);
        applyStimulus(1'b1, k3, 1'b0, 1'b0, 1'b0, 4'd0);
        checkOutput("wait_exp_key", exp_key, k2);
        idle(10);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd0);
        checkOutput("rekey_rk0", rk, k2);

        $display("[TB] clear during expansion");
        applyStimulus(1'b1, k3, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(4);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd0);
        idle(8);
        checkOutput("clr_valid", 128'(keys_valid), 128'd0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'(i));

        $display("[TB] async reset in WAIT and VALID");
        applyStimulus(1'b1, k2, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(3);
        async_reset("rst_wait");
        applyStimulus(1'b1, AES_KEY, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(11);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd10);
        checkOutput("rst_tv_rk10", rk, AES_RK10);
        async_reset("rst_valid");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            rk_key = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(($urandom % 4) == 0, rk_key, ($urandom % 40) == 0, ($urandom % 5) == 0,
                          1'($urandom % 2),
                          (($urandom % 4) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
